// File: rtl/mips_pkg.sv
// mips_pkg: shared types for the MIPS program loader.
// Holds the loader state enum, the HLT opcode and the 32-bit word type.
package mips_pkg;

  typedef logic [31:0] word_t;

  localparam logic [5:0] OP_HLT = 6'h3f;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    DONE,
    ERR
  } ld_state_e;

endpackage

// File: rtl/mips_prog_loader_if.sv
// mips_prog_loader_if: loader bus bundle (stream in, memory write, cpu launch/status).
// master = loader side, slave = stream source / memory / cpu side.
interface mips_prog_loader_if #(
  parameter int unsigned MEM_AW = 10
);
  import mips_pkg::*;

  logic              go;
  logic              s_valid;
  word_t             s_data;
  logic              s_last;
  logic              s_ready;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  word_t             mem_wdata;
  logic              cpu_start;
  word_t             cpu_pc;
  logic              cpu_halted;
  logic              busy;
  logic              done;
  logic              err;
  logic [MEM_AW:0]   word_count;

  modport master (
    input  go, s_valid, s_data, s_last, cpu_halted,
    output s_ready, mem_we, mem_addr, mem_wdata,
    output cpu_start, cpu_pc, busy, done, err, word_count
  );

  modport slave (
    output go, s_valid, s_data, s_last, cpu_halted,
    input  s_ready, mem_we, mem_addr, mem_wdata,
    input  cpu_start, cpu_pc, busy, done, err, word_count
  );

endinterface

// File: rtl/mips_loader_csum.sv
// mips_loader_csum: running 32-bit XOR of loaded words (MIPS_LOADER_CHECKSUM_EN builds).
// Ports: clk1, rst_n, clr_i (restart), en_i (accumulate data_i), csum_o.
module mips_loader_csum
  import mips_pkg::*;
(
  input  logic  clk1,
  input  logic  rst_n,
  input  logic  clr_i,
  input  logic  en_i,
  input  word_t data_i,
  output word_t csum_o
);

  word_t csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (clr_i)     csum_d = '0;
    else if (en_i) csum_d = csum_q ^ data_i;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign csum_o = csum_q;

endmodule

// File: rtl/mips_prog_loader.sv
// mips_prog_loader: streams a program into cpu memory, launches it, waits for halt.
// Ports: clk1/rst_n, go, s_* stream in, mem_* write port, cpu_* launch/status,
// busy/done/err/word_count status. Option: MIPS_LOADER_CHECKSUM_EN (last beat = XOR checksum).
module mips_prog_loader
  import mips_pkg::*;
#(
  parameter int unsigned MEM_AW    = 10,
  parameter int unsigned LOAD_BASE = 0,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              go,
  input  logic              s_valid,
  input  word_t             s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output word_t             mem_wdata,
  output logic              cpu_start,
  output word_t             cpu_pc,
  input  logic              cpu_halted,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [MEM_AW:0]   word_count
);

  typedef logic [MEM_AW:0] cnt_t;

  localparam cnt_t              CNT_MAX = cnt_t'(MAX_WORDS);
  localparam logic [MEM_AW-1:0] BASE    = MEM_AW'(LOAD_BASE);

  ld_state_e state_q, state_d;
  cnt_t      cnt_q, cnt_d;
  cnt_t      cnt_inc;
  logic      xfer;
  logic      data_beat;
  logic      cs_ok;

  assign xfer    = s_valid && (state_q == LOAD);
  assign cnt_inc = cnt_q + cnt_t'(1);

`ifdef MIPS_LOADER_CHECKSUM_EN
  word_t csum;
  logic  csum_clr;

  // Restart the XOR whenever a new session begins.
  assign csum_clr  = go && (state_q == IDLE || state_q == DONE);
  // The s_last beat carries the checksum, not program text.
  assign data_beat = xfer && !s_last;
  assign cs_ok     = (csum == s_data);

  mips_loader_csum u_csum (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .clr_i  (csum_clr),
    .en_i   (data_beat),
    .data_i (s_data),
    .csum_o (csum)
  );
`else
  assign data_beat = xfer;
  assign cs_ok     = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (go) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (xfer) begin
          if (data_beat) cnt_d = cnt_inc;
          // s_last wins over a simultaneous capacity hit.
          if (s_last)                 state_d = cs_ok ? START : ERR;
          else if (cnt_inc == CNT_MAX) state_d = ERR;
        end
      end
      START:   state_d = RUN;
      RUN:     if (cpu_halted) state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s_ready    = (state_q == LOAD);
  assign mem_we     = data_beat;
  assign mem_addr   = BASE + cnt_q[MEM_AW-1:0];
  assign mem_wdata  = s_data;
  assign cpu_start  = (state_q == START);
  assign cpu_pc     = 32'(BASE);
  assign busy       = (state_q == LOAD) || (state_q == START) ||
                      (state_q == RUN);
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);
  assign word_count = cnt_q;

`ifndef SYNTHESIS
  // A program must fit below 2**MEM_AW; a wrap means a bad parameter set.
  always @(posedge clk1) begin
    if (rst_n && mem_we) begin
      assert ((LOAD_BASE + 32'(cnt_q)) < (32'd1 << MEM_AW))
        else $error("loader address wraps past 2**MEM_AW");
    end
  end
`endif

endmodule

// File: tb/tb_mips_prog_loader.sv
// tb_mips_prog_loader: self-checking bench for mips_prog_loader.
// Table vectors on a small instance, randomized sessions vs a reference model on the default one.
module tb_mips_prog_loader;
  import mips_pkg::*;

`ifdef MIPS_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic clk1 = 1'b0;
  logic rst_n;
  always #5 clk1 = ~clk1;

  int nchk = 0;
  int nerr = 0;

  // default instance, driven through the interface
  mips_prog_loader_if #(.MEM_AW(10)) lif ();

  mips_prog_loader dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .go         (lif.go),
    .s_valid    (lif.s_valid),
    .s_data     (lif.s_data),
    .s_last     (lif.s_last),
    .s_ready    (lif.s_ready),
    .mem_we     (lif.mem_we),
    .mem_addr   (lif.mem_addr),
    .mem_wdata  (lif.mem_wdata),
    .cpu_start  (lif.cpu_start),
    .cpu_pc     (lif.cpu_pc),
    .cpu_halted (lif.cpu_halted),
    .busy       (lif.busy),
    .done       (lif.done),
    .err        (lif.err),
    .word_count (lif.word_count)
  );

  // small instance: base 8, capacity 4
  logic        g4, v4, l4, h4, r4, we4, st4, b4, dn4, er4;
  word_t       d4, wd4, pc4;
  logic [9:0]  a4;
  logic [10:0] c4;

  mips_prog_loader #(.MEM_AW(10), .LOAD_BASE(8), .MAX_WORDS(4)) dut4 (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .go         (g4),
    .s_valid    (v4),
    .s_data     (d4),
    .s_last     (l4),
    .s_ready    (r4),
    .mem_we     (we4),
    .mem_addr   (a4),
    .mem_wdata  (wd4),
    .cpu_start  (st4),
    .cpu_pc     (pc4),
    .cpu_halted (h4),
    .busy       (b4),
    .done       (dn4),
    .err        (er4),
    .word_count (c4)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // write monitor on the default instance
  typedef struct packed {
    logic [9:0] a;
    word_t      d;
  } wr_t;

  wr_t wlog[$];
  int  nstart;

  always @(negedge clk1) begin
    if (lif.mem_we) wlog.push_back('{lif.mem_addr, lif.mem_wdata});
    if (lif.cpu_start) nstart++;
  end

  // one beat with a random idle gap first; bounded wait for s_ready
  task automatic send(input word_t w, input logic last, input int gapmax,
                      output bit ok);
    int g;
    g = $urandom_range(0, gapmax);
    for (int k = 0; k < g; k++) begin
      lif.s_data = $urandom;
      @(posedge clk1); #1;
    end
    lif.s_valid = 1'b1;
    lif.s_data  = w;
    lif.s_last  = last;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk1);
      ok = lif.s_ready;
      @(posedge clk1); #1;
    end
    lif.s_valid = 1'b0;
    lif.s_last  = 1'b0;
  endtask

  // full session on the default instance, checked against a simple model:
  // word i lands at address i; count = words; start iff checksum agrees.
  task automatic session(input word_t w[$], input int gapmax,
                         input int hdly, input word_t csmask);
    wr_t   exp[$];
    word_t x;
    bit    ok;
    bit    exp_start;
    int    n;
    n = w.size();
    x = '0;
    for (int i = 0; i < n; i++) begin
      exp.push_back('{10'(i), w[i]});
      x ^= w[i];
    end
`ifdef MIPS_LOADER_CHECKSUM_EN
    exp_start = (csmask == 0);
`else
    exp_start = 1'b1;
`endif
    wlog.delete();
    nstart = 0;
    lif.go = 1'b1;
    @(posedge clk1); #1;
    lif.go = 1'b0;
    for (int i = 0; i < n; i++) begin
      send(w[i], (i == n - 1) && !CS, gapmax, ok);
      chk($sformatf("accept[%0d]", i), ok, 1);
    end
`ifdef MIPS_LOADER_CHECKSUM_EN
    send(x ^ csmask, 1'b1, gapmax, ok);
    chk("accept_csum", ok, 1);
`endif
    @(negedge clk1);
    chk("word_count", lif.word_count, n);
    chk("nwrites", wlog.size(), n);
    for (int i = 0; i < n && i < wlog.size(); i++) begin
      chk($sformatf("waddr[%0d]", i), wlog[i].a, exp[i].a);
      chk($sformatf("wdata[%0d]", i), wlog[i].d, exp[i].d);
    end
    if (exp_start) begin
      chk("cpu_start", lif.cpu_start, 1);
      chk("cpu_pc", lif.cpu_pc, 0);
      @(posedge clk1); #1;
      for (int k = 0; k < hdly; k++) begin
        @(posedge clk1); #1;
      end
      lif.cpu_halted = 1'b1;
      @(negedge clk1);
      chk("run_busy", lif.busy, 1);
      chk("run_done", lif.done, 0);
      @(posedge clk1); #1;
      lif.cpu_halted = 1'b0;
      @(negedge clk1);
      chk("done", lif.done, 1);
      chk("done_busy", lif.busy, 0);
      chk("start_cycles", nstart, 1);
      @(posedge clk1); #1;
    end else begin
      chk("csum_err", lif.err, 1);
      chk("csum_ready", lif.s_ready, 0);
      chk("start_cycles", nstart, 0);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      @(posedge clk1); #1;
    end
  endtask

  typedef struct {
    logic        go, sv;
    word_t       d;
    logic        last, halt;
    logic        e_rdy, e_we;
    logic [9:0]  e_a;
    logic        e_busy, e_st, e_dn, e_er;
    logic [10:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(logic go, logic sv, word_t d, logic last,
                              logic halt, logic rdy, logic we, int a,
                              logic bsy, logic st, logic dn, logic er,
                              int cnt);
    vec_t v;
    v = '{go, sv, d, last, halt, rdy, we, 10'(a), bsy, st, dn, er, 11'(cnt)};
    return v;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t  tv[14];
    word_t prog[$];
    word_t w[$];
    bit    ok;
    int    c2;
    localparam word_t A = 32'h1111_0001;
    localparam word_t C = 32'hc0de_0003;
    localparam word_t D = 32'hd00d_0004;
    localparam word_t E = 32'he00e_0005;
    localparam word_t F = 32'hf00f_0006;
    localparam word_t G = 32'h6666_0007;

    c2 = CS ? 1 : 2;
    //           go sv d  ls ht rdy we      a  bsy st dn er cnt
    tv[0]  = mk(0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0);
    tv[1]  = mk(1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0);
    tv[2]  = mk(0, 1, A, 0, 0, 1, 1,      8, 1, 0, 0, 0, 0);
    tv[3]  = mk(0, 0, 0, 0, 0, 1, 0,      0, 1, 0, 0, 0, 1);
    tv[4]  = mk(0, 1, A, 1, 0, 1, !CS,    9, 1, 0, 0, 0, 1);
    tv[5]  = mk(0, 0, 0, 0, 1, 0, 0,      0, 1, 1, 0, 0, c2);
    tv[6]  = mk(0, 0, 0, 0, 1, 0, 0,      0, 1, 0, 0, 0, c2);
    tv[7]  = mk(1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, c2);
    tv[8]  = mk(0, 1, C, 0, 0, 1, 1,      8, 1, 0, 0, 0, 0);
    tv[9]  = mk(0, 1, D, 0, 0, 1, 1,      9, 1, 0, 0, 0, 1);
    tv[10] = mk(0, 1, E, 0, 0, 1, 1,     10, 1, 0, 0, 0, 2);
    tv[11] = mk(0, 1, F, 0, 0, 1, 1,     11, 1, 0, 0, 0, 3);
    tv[12] = mk(0, 1, G, 0, 0, 0, 0,      0, 0, 0, 0, 1, 4);
    tv[13] = mk(1, 1, G, 0, 0, 0, 0,      0, 0, 0, 0, 1, 4);

    rst_n = 1'b0;
    lif.go = 0; lif.s_valid = 0; lif.s_data = 0;
    lif.s_last = 0; lif.cpu_halted = 0;
    g4 = 0; v4 = 0; d4 = 0; l4 = 0; h4 = 0;
    nstart = 0;
    repeat (2) @(posedge clk1);
    #1;
    chk("rst_ready", lif.s_ready, 0);
    chk("rst_we", lif.mem_we, 0);
    chk("rst_start", lif.cpu_start, 0);
    chk("rst_busy", lif.busy, 0);
    chk("rst_done", lif.done, 0);
    chk("rst_err", lif.err, 0);
    chk("rst_count", lif.word_count, 0);
    chk("rst_pc", lif.cpu_pc, 0);
    chk("rst_pc4", pc4, 8);
    rst_n = 1'b1;

    // table vectors on the base-8, capacity-4 instance
    for (int i = 0; i < 14; i++) begin
      g4 = tv[i].go;
      v4 = tv[i].sv;
      d4 = tv[i].d;
      l4 = tv[i].last;
      h4 = tv[i].halt;
      @(negedge clk1);
      chk($sformatf("v%0d.s_ready", i), r4, tv[i].e_rdy);
      chk($sformatf("v%0d.mem_we", i), we4, tv[i].e_we);
      chk($sformatf("v%0d.busy", i), b4, tv[i].e_busy);
      chk($sformatf("v%0d.cpu_start", i), st4, tv[i].e_st);
      chk($sformatf("v%0d.done", i), dn4, tv[i].e_dn);
      chk($sformatf("v%0d.err", i), er4, tv[i].e_er);
      chk($sformatf("v%0d.word_count", i), c4, tv[i].e_cnt);
      if (tv[i].e_we) begin
        chk($sformatf("v%0d.mem_addr", i), a4, tv[i].e_a);
        chk($sformatf("v%0d.mem_wdata", i), wd4, tv[i].d);
      end
      @(posedge clk1); #1;
    end
    chk("ovf_pc4", pc4, 8);
    g4 = 0; v4 = 0;

`ifndef MIPS_LOADER_CHECKSUM_EN
    // reference program, no gaps, halt 40 cycles after cpu_start
    prog = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000,
             32'h0e94a000, 32'h14431000, 32'h2c630001, 32'h0e94a000,
             32'h3460fffc, 32'h2542fffe, 32'hfc000000};
    session(prog, 0, 39, 0);
`endif

    // backpressure: 5 words with random s_valid gaps
    w = '{};
    for (int i = 0; i < 5; i++) w.push_back($urandom);
    session(w, 3, 2, 0);

    // randomized sessions
    for (int s = 0; s < 12; s++) begin
      int    n;
      word_t m;
      n = $urandom_range(1, 12);
      w = '{};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      m = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h1) : 32'h0;
      session(w, $urandom_range(0, 2), $urandom_range(0, 6), m);
    end

    // reset in the middle of a load
    wlog.delete();
    lif.go = 1'b1;
    @(posedge clk1); #1;
    lif.go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(32'hab00_0000 + 32'(i), 1'b0, 0, ok);
      chk($sformatf("mid_accept[%0d]", i), ok, 1);
    end
    lif.s_valid = 1'b1;
    lif.s_data  = 32'hab00_0003;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", lif.mem_we, 0);
    chk("mid_rst_ready", lif.s_ready, 0);
    chk("mid_rst_busy", lif.busy, 0);
    chk("mid_rst_count", lif.word_count, 0);
    rst_n = 1'b1;
    lif.s_valid = 1'b0;
    repeat (2) begin
      @(posedge clk1); #1;
    end
    chk("mid_rst_nwrites", wlog.size(), 3);
    w = '{32'h1234_5678, 32'h9abc_def0};
    session(w, 1, 0, 0);

`ifdef MIPS_LOADER_CHECKSUM_EN
    // checksum 0x3 over {1,2} passes; 0x4 fails
    w = '{32'h1, 32'h2};
    session(w, 0, 0, 32'h0);
    session(w, 0, 0, 32'h7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/mips_prog_loader.md
MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, meaning the memory word-address width.
REQ-002 SHALL have parameter LOAD_BASE, default 0, meaning the first program word address and the processor start PC.
REQ-003 SHALL have parameter MAX_WORDS, default 64, meaning the program capacity in words.
REQ-004 SHALL have port clk1, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port go, input, 1 bit: start a load session (sampled in IDLE).
REQ-007 SHALL have ports s_valid (input, 1), s_data (input, 32), s_last (input, 1) and s_ready (output, 1): instruction stream in.
REQ-008 SHALL have ports mem_we (output, 1), mem_addr (output, MEM_AW) and mem_wdata (output, 32): processor memory write port.
REQ-009 SHALL have ports cpu_start (output, 1), cpu_pc (output, 32) and cpu_halted (input, 1): processor launch and status.
REQ-010 SHALL have ports busy, done and err (outputs, 1 each) and word_count (output, MEM_AW+1).

Function
REQ-011 SHALL implement states IDLE, LOAD, START, RUN, DONE and ERR.
REQ-012 IDLE: go=1 -> LOAD and clear word_count to 0; otherwise hold.
REQ-013 LOAD: s_ready=1; a beat transfers only when s_valid and s_ready are both 1.
REQ-014 On each transfer, in the same cycle: mem_we=1, mem_addr=LOAD_BASE+word_count, mem_wdata=s_data; word_count increments next edge.
REQ-015 Transfer with s_last=1 -> START; word_count includes that final word.
REQ-016 Transfer making word_count==MAX_WORDS with s_last=0 -> ERR; that last word is still written.
REQ-017 s_valid=0 in LOAD: no write, state held, no timeout.
REQ-018 START: exactly one cycle; cpu_start=1, cpu_pc=LOAD_BASE; then -> RUN.
REQ-019 RUN: wait for cpu_halted=1, then -> DONE; cpu_halted already 1 on RUN entry -> DONE on the next edge.
REQ-020 DONE: done=1; go=1 -> LOAD (new session, word_count cleared).
REQ-021 ERR: err=1, s_ready=0; exit only via reset.
REQ-022 busy=1 in LOAD, START and RUN; s_ready=0 and mem_we=0 outside LOAD.
REQ-023 cpu_pc SHALL hold LOAD_BASE at all times after reset, zero-extended to 32 bits.
REQ-024 Address arithmetic SHALL be MEM_AW bits wide; wrap-around beyond 2^MEM_AW is a configuration error, checked by a simulation-only assertion.

Reset
REQ-025 rst_n=0 SHALL force IDLE immediately, regardless of clock.
REQ-026 rst_n=0 SHALL drive word_count=0, s_ready=0, mem_we=0, cpu_start=0, busy=0, done=0 and err=0.
REQ-027 Reset during LOAD SHALL abort the session with no further writes; already-written words are not cleared.

Configuration
REQ-028 With MIPS_LOADER_CHECKSUM_EN defined, the beat with s_last=1 SHALL be a checksum word, not written to memory and not counted.
REQ-029 With MIPS_LOADER_CHECKSUM_EN defined, that checksum word SHALL be compared with the XOR of all prior words: match -> START; mismatch -> ERR.
REQ-030 Without MIPS_LOADER_CHECKSUM_EN, the s_last beat SHALL be an ordinary instruction word per REQ-015.

Structure
REQ-031 The shared package mips_pkg SHALL hold the loader state enum, the HLT opcode constant (6'h3f) and the 32-bit word type.
REQ-032 Checksum accumulation SHALL live in sub-module mips_loader_csum (clear, enable, data, 32-bit running XOR), instantiated only under the macro.

Verification
REQ-033 Program load: go, then stream 11 words 0x280a00c8, 0x28020001, 0x0e94a000, 0x21430000, 0x0e94a000, 0x14431000, 0x2c630001, 0x0e94a000, 0x3460fffc, 0x2542fffe, 0xfc000000 (last on the 11th) -> writes at addresses 0..10, word_count=11, cpu_start high for exactly one cycle on the edge after the last beat, cpu_pc=0.
REQ-034 Halt: cpu_halted rises 40 cycles after cpu_start -> done=1 the next cycle, busy=0.
REQ-035 Backpressure gaps: toggle s_valid randomly across 5 words -> exactly 5 writes at consecutive addresses, none duplicated.
REQ-036 Overflow: MAX_WORDS=4, stream 5 words with no s_last -> 4 writes, err=1, s_ready=0, 5th word not accepted.
REQ-037 Mid-load reset: assert rst_n=0 after word 3 -> IDLE asynchronously, mem_we=0 before the next edge; a fresh go reloads from address LOAD_BASE.
REQ-038 Checksum (macro on): words 0x1, 0x2, then checksum 0x3 with s_last -> word_count=2, START; checksum 0x4 -> ERR.
